// File: rtl/timeout_counter_pkg.sv
// Shared timer definitions: state encodings and default sizing reused by
// every timeout_counter instance.
package timeout_counter_pkg;

  localparam int TC_WIDTH       = 4;
  localparam int TC_RESET_LIMIT = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } tc_state_e;

endpackage

// File: rtl/timeout_counter.sv
// Programmable tick counter: counts qualified enables up to a loadable limit
// and emits a one-cycle timeout pulse; one-shot or periodic, with hold/abort/retrigger.
module timeout_counter
  import timeout_counter_pkg::*;
#(
  parameter int WIDTH       = TC_WIDTH,
  parameter int RESET_LIMIT = TC_RESET_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             periodic,
  input  logic             load,
  input  logic [WIDTH-1:0] limit_in,
  output logic             timeout,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  tc_state_e        r_state, w_nxt_state;
  logic [WIDTH-1:0] r_count, w_nxt_count;
  logic [WIDTH-1:0] r_lim;
  logic             r_timeout, w_nxt_timeout;
  logic             r_busy;
  logic [WIDTH-1:0] w_term;
  logic             w_is_term;

  // lim=0 wraps to all-ones, giving a full 2^WIDTH tick run; >= catches a
  // limit lowered below the current count.
  assign w_term    = r_lim - WIDTH'(1);
  assign w_is_term = (r_count >= w_term);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_count   = r_count;
    w_nxt_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nxt_count = '0;
        if (start) w_nxt_state = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          w_nxt_state = ST_IDLE;
          w_nxt_count = '0;
        end else if (start) begin
          w_nxt_count = '0;
        end else if (hold) begin
          w_nxt_state = ST_HOLD;
        end else if (enable && w_is_term) begin
          w_nxt_count   = '0;
          w_nxt_timeout = 1'b1;
          w_nxt_state   = periodic ? ST_RUN : ST_IDLE;
        end else if (enable) begin
          w_nxt_count = r_count + WIDTH'(1);
        end
      end
      ST_HOLD: begin
        if (stop) begin
          w_nxt_state = ST_IDLE;
          w_nxt_count = '0;
        end else if (start) begin
          w_nxt_state = ST_RUN;
          w_nxt_count = '0;
        end else if (!hold) begin
          w_nxt_state = ST_RUN;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_count = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
      r_lim     <= WIDTH'(RESET_LIMIT);
    end else begin
      r_state   <= w_nxt_state;
      r_count   <= w_nxt_count;
      r_timeout <= w_nxt_timeout;
      r_busy    <= (w_nxt_state == ST_RUN) || (w_nxt_state == ST_HOLD);
      if (load) r_lim <= limit_in;
    end
  end

  assign timeout = r_timeout;
  assign busy    = r_busy;
  assign count   = r_count;

endmodule

// File: tb/tb_timeout_counter.sv
// Directed scenarios plus randomized traffic, compared every cycle against a
// tick-counting reference model.
module tb_timeout_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, enable, start, stop, hold, periodic, load;
  logic [W-1:0] limit_in;
  logic         timeout, busy;
  logic [W-1:0] count;

  int n_chk  = 0;
  int n_pass = 0;
  int pulses = 0;

  // reference model: run flag, hold flag, ticks taken, current limit
  bit m_run, m_hold, m_to;
  int m_n, m_lim;

  always #5 clk = ~clk;

  timeout_counter #(.WIDTH(W), .RESET_LIMIT(10)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop),
    .hold(hold), .periodic(periodic), .load(load), .limit_in(limit_in),
    .timeout(timeout), .busy(busy), .count(count)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_update();
    int period;
    m_to = 1'b0;
    if (rst) begin
      m_run = 0; m_hold = 0; m_n = 0; m_lim = 10;
    end else begin
      period = (m_lim == 0) ? (1 << W) : m_lim;
      if (!m_run) begin
        if (start) begin m_run = 1; m_n = 0; end
      end else if (stop) begin
        m_run = 0; m_hold = 0; m_n = 0;
      end else if (start) begin
        m_hold = 0; m_n = 0;
      end else if (m_hold) begin
        if (!hold) m_hold = 0;
      end else if (hold) begin
        m_hold = 1;
      end else if (enable) begin
        if (m_n + 1 >= period) begin
          m_to = 1; m_n = 0;
          if (!periodic) m_run = 0;
        end else m_n++;
      end
      if (load) m_lim = int'(limit_in);
    end
  endtask

  // drive one cycle of inputs, clock it, then compare all outputs
  task automatic step(input bit en, input bit st, input bit sp, input bit hd,
                      input bit per, input bit ld, input int li, input bit rs);
    enable = en; start = st; stop = sp; hold = hd; periodic = per;
    load = ld; limit_in = W'(li); rst = rs;
    @(posedge clk);
    model_update();
    #1;
    if (timeout) pulses++;
    check("timeout", int'(timeout), int'(m_to));
    check("busy",    int'(busy),    int'(m_run));
    check("count",   int'(count),   m_n);
  endtask

  task automatic idle_cycles(input int n, input bit per);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, per, 0, 0, 0);
  endtask

  initial begin
    m_run = 0; m_hold = 0; m_n = 0; m_lim = 10; m_to = 0;
    rst = 1; enable = 0; start = 0; stop = 0; hold = 0; periodic = 0;
    load = 0; limit_in = '0;

    // reset state
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 1);
    check("reset_count_zero", int'(count), 0);

    // one-shot, lim=10, enable continuous: exactly one pulse
    pulses = 0;
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    check("oneshot_pulses", pulses, 1);

    // periodic lim=3, enable every other cycle, then stop
    pulses = 0;
    step(0, 1, 0, 0, 1, 1, 3, 0);
    for (int i = 0; i < 18; i++) step(i % 2 == 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0, 0);
    idle_cycles(4, 1);
    check("periodic_pulses", pulses, 3);

    // hold at count 5 for 7 cycles, then release
    step(0, 1, 0, 0, 0, 1, 10, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 0, 0, 0, 0);
    check("hold_count", int'(count), 5);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // lower limit below current count (6): next enable fires
    step(0, 0, 0, 0, 0, 1, 4, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("lowered_limit_fire", int'(timeout), 1);

    // stop+start at terminal tick (lim=4, count=3)
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    check("stop_start_term_busy", int'(busy), 0);
    // start alone at terminal tick
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    check("start_term_busy", int'(busy), 1);
    // reset at count 7 (lim back to 10 via load)
    step(0, 1, 0, 0, 0, 1, 10, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    check("rst_midrun_timeout", int'(timeout), 0);

    // lim=1 periodic: pulse every cycle
    pulses = 0;
    step(0, 1, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1, 0, 0, 0);
    check("lim1_pulses", pulses, 6);
    step(0, 0, 1, 0, 1, 0, 0, 0);

    // lim=0: pulse after 16 enables
    pulses = 0;
    step(0, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    check("lim0_no_early", pulses, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("lim0_pulse16", int'(timeout), 1);
    idle_cycles(2, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 65,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 12,
           (i / 200) % 2 == 1,
           $urandom_range(0, 99) < 5,
           int'($urandom_range(0, 15)),
           $urandom_range(0, 999) < 5);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
